pulse_stretcher: RTL

Expands single-cycle event pulses (e.g. from the button edge-detect/one-shot stage) into fixed-width, human/slow-domain visible levels. It is the inverse of the press-to-pulse path: pulse in, timed level out, with a minimum low gap between outputs. Events arriving while an output is in progress are queued in a saturating counter and replayed, or optionally retrigger the current hold. It sits between the button conditioning logic and LED drivers or slow peripheral strobes.

---
 rtl/pulse_stretcher_pkg.sv | 20 ++
 rtl/pulse_stretcher_timer.sv | 29 ++
 rtl/pulse_stretcher.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Timer must hold the larger of the two reload values (count - 1); never narrower than 1 bit.
    function automatic int unsigned timer_width(input int unsigned hold_cycles,
                                                input int unsigned gap_cycles);
        int unsigned longest;
        int unsigned width;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter that parks at zero; load has priority over counting.
module stretch_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] value_q;

    // Count down to zero and stop there; a reload always arrives before it would wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_value;
        end else if (value_q != '0) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width levels with a minimum low gap.
// Events arriving while busy are queued in a saturating counter, or retrigger the hold.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 2,
    parameter int unsigned RETRIGGER   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned       TW        = timer_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_e            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              level_q, busy_q;
    logic              enq;

    logic              tmr_load;
    logic [TW-1:0]     tmr_load_value;
    logic [TW-1:0]     tmr_value;
    logic              tmr_zero;

    stretch_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    // Next-state, queue and timer-load decisions.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        ovf_d          = ovf_q & ~clear_ovf;
        tmr_load       = 1'b0;
        tmr_load_value = HOLD_LOAD;
        enq            = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                end
            end
            HOLD: begin
                if (pulse_in && (RETRIGGER != 0)) begin
                    // Retrigger beats the hold->gap transition on the last cycle.
                    tmr_load = 1'b1;
                end else begin
                    enq = pulse_in;
                    if (tmr_zero) begin
                        state_d        = GAP;
                        tmr_load       = 1'b1;
                        tmr_load_value = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    // A pulse on the final gap cycle is consumed directly as the next event,
                    // so a concurrent enqueue/dequeue leaves the count untouched.
                    if ((pend_q != '0) || pulse_in) begin
                        state_d  = HOLD;
                        tmr_load = 1'b1;
                        if (!pulse_in) begin
                            pend_d = pend_q - 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    enq = pulse_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Overflow set wins over a same-cycle clear.
        if (enq) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end
    end

    // State, queue and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule
